// File: rtl/cp0_irq.sv
// Coprocessor-0 interrupt/exception block for the pipelined MIPS core: SR, Cause,
// EPC, PRId and an optional Count/Compare timer, sitting beside the M stage.
module cp0_irq #(
  parameter int          NUM_HWINT = 5,
  parameter logic [4:0]  EDGE_MASK = 5'b00000,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID      = 32'h1837_3584
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 we,
  input  logic [31:0]          pc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exl_clr,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic [31:0]          rd_data,
  output logic                 timer_irq
);

  logic [5:0]           im_q, im_d;
  logic                 exl_q, exl_d, ie_q, ie_d;
  logic [NUM_HWINT-1:0] ip_hw_q, ip_hw_d, hist_q, hist_d;
  logic                 ip_tmr_q, ip_tmr_d;
  logic                 dc_q, dc_d, bd_q, bd_d;
  logic [4:0]           exc_q, exc_d;
  logic [31:0]          epc_q, epc_d, count_q, count_d, compare_q, compare_d;

  logic [5:0]  ip;
  logic        int_pend;
  logic        wr_count, wr_cmp, wr_sr, wr_cause, wr_epc;
  logic [31:0] pc_adj;

  always_comb begin
    ip = {ip_tmr_q, 5'b00000};
    ip[NUM_HWINT-1:0] = ip_hw_q;
    int_pend = ie_q & ~exl_q & |(ip & im_q);
    int_req  = ~reset & ~exl_q & (int_pend | (exc_code != 5'd0));
  end

  assign epc       = epc_q;
  assign timer_irq = ip_tmr_q;

  always_comb begin
    wr_count = we && (wr_addr == 5'd9);
    wr_cmp   = we && (wr_addr == 5'd11);
    wr_sr    = we && (wr_addr == 5'd12);
    wr_cause = we && (wr_addr == 5'd13);
    wr_epc   = we && (wr_addr == 5'd14);
    pc_adj   = bd_in ? pc - 32'd4 : pc;

    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    dc_d      = dc_q;
    bd_d      = bd_q;
    exc_d     = exc_q;
    epc_d     = epc_q;
    hist_d    = hw_int;
    ip_hw_d   = ip_hw_q;
    ip_tmr_d  = 1'b0;
    count_d   = count_q;
    compare_d = compare_q;

    // mtc0 is lowest priority; eret and then exception entry override it below
    if (wr_sr) begin
      im_d  = wr_data[15:10];
      exl_d = wr_data[1];
      ie_d  = wr_data[0];
    end
    if (wr_epc)   epc_d = wr_data & ~32'h3;
    if (wr_cause) dc_d  = wr_data[27];

    // A new edge beats a same-cycle software clear so no edge is dropped
    for (int i = 0; i < NUM_HWINT; i++) begin
      if (EDGE_MASK[i])
        ip_hw_d[i] = (ip_hw_q[i] & ~(wr_cause & ~wr_data[10+i])) | (hw_int[i] & ~hist_q[i]);
      else
        ip_hw_d[i] = hw_int[i];
    end

    if (TIMER_EN) begin
      count_d   = wr_count ? wr_data : (dc_q ? count_q : count_q + 32'd1);
      compare_d = wr_cmp ? wr_data : compare_q;
      ip_tmr_d  = ~wr_cmp & (ip_tmr_q | (count_q == compare_q));
    end

    if (exl_clr) exl_d = 1'b0;

    if (int_req) begin
      exl_d = 1'b1;
      exc_d = int_pend ? 5'd0 : exc_code;
      bd_d  = bd_in;
      epc_d = pc_adj & ~32'h3;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      5'd9:  rd_data = TIMER_EN ? count_q : 32'd0;
      5'd11: rd_data = TIMER_EN ? compare_q : 32'd0;
      5'd12: rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13: rd_data = {bd_q, 3'd0, dc_q, 11'd0, ip, 3'd0, exc_q, 2'd0};
      5'd14: rd_data = epc_q;
      5'd15: rd_data = PRID;
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      ip_hw_q   <= '0;
      hist_q    <= '0;
      ip_tmr_q  <= 1'b0;
      dc_q      <= 1'b0;
      bd_q      <= 1'b0;
      exc_q     <= '0;
      epc_q     <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      ip_hw_q   <= ip_hw_d;
      hist_q    <= hist_d;
      ip_tmr_q  <= ip_tmr_d;
      dc_q      <= dc_d;
      bd_q      <= bd_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

endmodule

// File: doc/cp0_irq.md
# cp0_irq

Parametrised coprocessor-0 for the pipelined MIPS core. It supports a configurable number of external interrupt lines, with level or edge sensing selected per line. It adds an internal Count/Compare timer interrupt and a Cause.DC bit that freezes the timer. It sits beside the M stage: it takes the exception code, PC and branch-delay flag of the instruction in M, and returns the interrupt/exception request, EPC and the mfc0 read data.

## Interface
- NUM_HWINT, 5, number of external interrupt lines (1..5); they map to IM/IP bits [10 +: NUM_HWINT]
- EDGE_MASK, 5'b00000, per-line sensing: bit i = 1 means line i is edge-triggered, 0 means level
- TIMER_EN, 1, 1 = implement Count/Compare, timer interrupt on IM/IP bit 15; 0 = Count/Compare read 0, timer bit always 0
- PRID, 32'h1837_3584, read-only PRId value
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  5  mfc0 register number
- wr_addr  in  5  mtc0 register number
- wr_data  in  32  mtc0 data
- we  in  1  mtc0 write enable
- pc  in  32  PC of the M-stage instruction (word aligned)
- bd_in  in  1  M-stage instruction is in a delay slot
- exc_code  in  5  M-stage exception code; 0 = none
- hw_int  in  NUM_HWINT  external interrupt lines
- exl_clr  in  1  eret: clear SR.EXL
- int_req  out  1  take exception/interrupt this cycle (flush + vector)
- epc  out  32  current EPC, bits [1:0] = 0
- rd_data  out  32  combinational mfc0 data
- timer_irq  out  1  Cause bit 15 (timer pending)

## Operation
- Register map, any other address reads 0 and ignores writes:
  - 9 Count
  - 11 Compare
  - 12 SR = {16'b0, IM[15:10], 8'b0, EXL, IE}
  - 13 Cause = {BD, 3'b0, DC, 11'b0, IP[15:10], 3'b0, ExcCode, 2'b0}
  - 14 EPC
  - 15 PRId
- IP, level line i: register bit 10+i samples hw_int[i] every cycle.
- IP, edge line i: the bit sets on a 0→1 transition of hw_int[i]; the previous value is held in a per-line register. It stays set until mtc0 Cause writes 0 to that bit. Writing 1 has no effect.
- IP[15] (timer pending): sets on the cycle after Count == Compare. Cleared by any mtc0 Compare write.
- Count: when DC = 0, Count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0. An mtc0 Count write overrides that cycle's increment.
- int_pend = IE & ~EXL & |(IP[15:10] & IM[15:10]).
- int_req = ~EXL & (int_pend | exc_code != 0). Forced 0 while reset is high.
- Entry (int_req = 1 at the clock edge):
  - EXL <= 1
  - ExcCode <= int_pend ? 0 : exc_code (an interrupt has priority over an exception)
  - BD <= bd_in
  - EPC <= bd_in ? pc − 4 : pc
- While EXL = 1, nothing is taken and EPC/BD/ExcCode hold.
- exl_clr: EXL <= 0 the next edge.
- mtc0 writable fields:
  - SR: IM, EXL, IE
  - Cause: DC, and IP bits of edge lines (clear-only)
  - EPC: bits [31:2]
  - Count, Compare
- PRId is read-only.
- Same-edge priority for EXL/EPC/BD/ExcCode: entry > exl_clr > mtc0.

## Timing
- Async reset, all regs: SR = 0, Cause = 0, EPC = 0, Count = 0, Compare = 32'hFFFF_FFFF, edge history = 0.
- Outputs during/after reset: int_req = 0, timer_irq = 0, epc = 0.
- rd_data is combinational from rd_addr. It shows the pre-edge value on a same-cycle mtc0 to the same register; no internal bypass.
- Latencies:
  - External line change → IP visible: 1 cycle.
  - IP set → int_req: combinational in that same cycle.
  - Count == Compare → timer_irq: 1 cycle.
- Wrap-around: Compare = 0 fires on the cycle after Count wraps to 0. DC = 1 freezes Count, so no new match occurs.
- An edge pulse shorter than one cycle that is not sampled high is lost; a sampled 1 after a sampled 0 counts as one edge.
- Reset asserted mid-entry: all state cleared; no partial EPC update.

## Test plan
- Reset, then read SR/Cause/EPC/Count/Compare/PRId → 0/0/0/0/FFFF_FFFF/1837_3584; int_req = 0.
- SR = 0x0000_0401, pulse hw_int[0] (level, 1 cycle high) → IP[10] set the next cycle, int_req the same cycle, EXL = 1 and ExcCode = 0 after the edge, EPC = pc.
- exc_code = 12, bd_in = 1, pc = 0x3010, EXL = 0 → int_req = 1; after the edge Cause = 0x8000_0030 and EPC = 0x300C; eret clears EXL.
- EDGE_MASK = 5'b00010: hold hw_int[1] high 10 cycles → IP[11] set once and stays set after the line drops; mtc0 Cause with bit 11 = 0 clears it; writing 1 does not set it.
- Compare = 5 after reset, Count = 0 → timer_irq rises when Count reads 6; writing Compare clears it. Set DC = 1: Count holds and no further match occurs.
- Same cycle: int_pend = 1, exc_code = 4, mtc0 EPC = 0x1234 → entry wins; ExcCode = 0 and EPC = pc.
